// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver state encodings, frame geometry and parity helper.
package ps2_pkg;

  localparam int unsigned PS2_FRAME_BITS = 11;
  localparam int unsigned PS2_FILTER_LEN = 8;

  typedef enum logic [1:0] {
    RX_IDLE    = 2'd0,
    RX_RECEIVE = 2'd1,
    RX_DONE    = 2'd2
  } rx_state_t;

  // 1 when data plus parity bit carry an odd number of ones
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_clock_filter.sv
// PS/2 line conditioning: 2-flop synchronizers, ps2c glitch filter and falling-edge pulse.
module ps2_clock_filter
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = PS2_FILTER_LEN
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c,
  input  logic ps2d,
  output logic fall,
  output logic ps2d_s
);

  logic [1:0]            c_sync;
  logic [1:0]            d_sync;
  logic [FILTER_LEN-1:0] c_hist;
  logic                  c_filt;

  // Everything resets high so the idle bus cannot look like a falling edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_sync <= '1;
      d_sync <= '1;
      c_hist <= '1;
      c_filt <= 1'b1;
      fall   <= 1'b0;
    end else begin
      c_sync <= {c_sync[0], ps2c};
      d_sync <= {d_sync[0], ps2d};
      c_hist <= {c_hist[FILTER_LEN-2:0], c_sync[1]};
      fall   <= c_filt & ~(|c_hist);
      if (&c_hist) begin
        c_filt <= 1'b1;
      end else if (~(|c_hist)) begin
        c_filt <= 1'b0;
      end
    end
  end

  assign ps2d_s = d_sync[1];

endmodule

// File: rtl/ps2_receive.sv
// Host-side PS/2 device-to-host frame receiver with parity/stop checks and watchdog.
module ps2_receive
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = PS2_FILTER_LEN,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2d,
  input  logic       ps2c,
  input  logic       rx_en,
  output logic [7:0] data_out,
  output logic       rx_done,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_timeout,
  output logic       rx_busy
);

  localparam int unsigned SHIFT_W = PS2_FRAME_BITS - 1;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned WD_W    = $clog2(TIMEOUT_CYCLES);

  logic               fall;
  logic               ps2d_s;
  rx_state_t          state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [SHIFT_W-1:0] shift;
  logic [WD_W-1:0]    wd;

  ps2_clock_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk   (clk),
    .reset (reset),
    .ps2c  (ps2c),
    .ps2d  (ps2d),
    .fall  (fall),
    .ps2d_s(ps2d_s)
  );

  // Priority inside RECEIVE: rx_en abort, then falling edge, then watchdog
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RX_IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      wd         <= '0;
      data_out   <= '0;
      rx_done    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      rx_timeout <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      rx_done    <= 1'b0;
      rx_timeout <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (fall && rx_en && !ps2d_s) begin
            state   <= RX_RECEIVE;
            bit_cnt <= '0;
            wd      <= '0;
            rx_busy <= 1'b1;
          end
        end
        RX_RECEIVE: begin
          if (!rx_en) begin
            state   <= RX_IDLE;
            rx_busy <= 1'b0;
          end else if (fall) begin
            shift   <= {ps2d_s, shift[SHIFT_W-1:1]};
            bit_cnt <= bit_cnt + CNT_W'(1);
            wd      <= '0;
            if (bit_cnt == CNT_W'(SHIFT_W - 1)) begin
              state   <= RX_DONE;
              rx_busy <= 1'b0;
            end
          end else begin
            wd <= wd + WD_W'(1);
            if (wd == WD_W'(TIMEOUT_CYCLES - 2)) begin
              state      <= RX_IDLE;
              rx_timeout <= 1'b1;
              rx_busy    <= 1'b0;
            end
          end
        end
        RX_DONE: begin
          data_out   <= shift[7:0];
          parity_err <= ~odd_parity_ok(shift[8:0]);
          frame_err  <= ~shift[9];
          rx_done    <= 1'b1;
          state      <= RX_IDLE;
        end
        default: begin
          state   <= RX_IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_receive.sv
// Self-checking bench for ps2_receive: scoreboard of expected frames plus per-scenario tasks.
module tb_ps2_receive;

  localparam int unsigned FLT  = 8;
  localparam int unsigned TO   = 400;
  localparam int unsigned HALF = 30;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2d = 1'b1;
  logic       ps2c = 1'b1;
  logic       rx_en = 1'b1;
  logic [7:0] data_out;
  logic       rx_done;
  logic       parity_err;
  logic       frame_err;
  logic       rx_timeout;
  logic       rx_busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int drop_cyc = 0;
  int done_cnt = 0;
  int to_cnt = 0;
  int last_done_cyc = 0;
  int last_to_cyc = 0;
  exp_t exp_q[$];

  ps2_receive #(
    .FILTER_LEN(FLT),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2d      (ps2d),
    .ps2c      (ps2c),
    .rx_en     (rx_en),
    .data_out  (data_out),
    .rx_done   (rx_done),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .rx_timeout(rx_timeout),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every rx_done pulse must match the oldest expected frame
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      if (rx_done) begin
        exp_t e;
        done_cnt++;
        last_done_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_rx_done data_out=%02h expected no frame", data_out);
        end else begin
          e = exp_q.pop_front();
          if (data_out !== e.data) begin
            failures++;
            $display("FAIL data_out got=%02h exp=%02h", data_out, e.data);
          end
          checks++;
          if (parity_err !== e.perr) begin
            failures++;
            $display("FAIL parity_err data=%02h got=%0b exp=%0b", e.data, parity_err, e.perr);
          end
          checks++;
          if (frame_err !== e.ferr) begin
            failures++;
            $display("FAIL frame_err data=%02h got=%0b exp=%0b", e.data, frame_err, e.ferr);
          end
        end
      end
      if (rx_timeout) begin
        to_cnt++;
        last_to_cyc = cyc;
      end
    end
  end

  function automatic logic odd_par(input logic [7:0] d);
    return ~(^d);
  endfunction

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2d = b;
    repeat (HALF) @(negedge clk);
    ps2c = 1'b0;
    drop_cyc = cyc;
    repeat (HALF) @(negedge clk);
    ps2c = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(par);
    ps2_bit(stp);
    @(negedge clk);
    ps2d = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic push_exp(input logic [7:0] d, input logic pe, input logic fe);
    exp_t e;
    e.data = d;
    e.perr = pe;
    e.ferr = fe;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain pending=%0d expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({data_out, rx_done, parity_err, frame_err, rx_timeout, rx_busy} !== 13'd0) begin
      failures++;
      $display("FAIL %s outputs got=%b exp=0", name,
               {data_out, rx_done, parity_err, frame_err, rx_timeout, rx_busy});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check_all_zero("post_reset_idle");
  endtask

  task automatic test_single();
    int d0;
    d0 = done_cnt;
    push_exp(8'h1C, 1'b0, 1'b0);
    send_frame(8'h1C, odd_par(8'h1C), 1'b1);
    wait_drain("single");
    checks++;
    if (done_cnt != d0 + 1) begin
      failures++;
      $display("FAIL single_done_count got=%0d exp=%0d", done_cnt - d0, 1);
    end
    checks++;
    if (last_done_cyc - drop_cyc != int'(FLT) + 5) begin
      failures++;
      $display("FAIL done_latency got=%0d exp=%0d", last_done_cyc - drop_cyc, FLT + 5);
    end
    checks++;
    if (rx_busy !== 1'b0) begin
      failures++;
      $display("FAIL single_busy_after got=%0b exp=0", rx_busy);
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_cnt;
    push_exp(8'hF0, 1'b0, 1'b0);
    push_exp(8'h1C, 1'b0, 1'b0);
    send_frame(8'hF0, odd_par(8'hF0), 1'b1);
    repeat (100) @(negedge clk);
    send_frame(8'h1C, odd_par(8'h1C), 1'b1);
    wait_drain("back_to_back");
    checks++;
    if (done_cnt != d0 + 2) begin
      failures++;
      $display("FAIL b2b_done_count got=%0d exp=%0d", done_cnt - d0, 2);
    end
  endtask

  task automatic test_errors();
    push_exp(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1C, ~odd_par(8'h1C), 1'b1);
    wait_drain("parity_error");
    push_exp(8'h1C, 1'b0, 1'b1);
    send_frame(8'h1C, odd_par(8'h1C), 1'b0);
    wait_drain("stop_error");
    repeat (50) @(negedge clk);
    checks++;
    if (frame_err !== 1'b1 || parity_err !== 1'b0) begin
      failures++;
      $display("FAIL error_flags_hold got pe=%0b fe=%0b exp pe=0 fe=1", parity_err, frame_err);
    end
  endtask

  task automatic test_timeout();
    int d0, t0;
    d0 = done_cnt;
    t0 = to_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(i[0]);
    ps2d = 1'b1;
    for (int i = 0; i < int'(TO) + 100 && to_cnt == t0; i++) @(negedge clk);
    checks++;
    if (to_cnt != t0 + 1) begin
      failures++;
      $display("FAIL timeout_seen got=%0d exp=%0d", to_cnt - t0, 1);
    end
    checks++;
    if (last_to_cyc - drop_cyc != int'(TO) + int'(FLT) + 3) begin
      failures++;
      $display("FAIL timeout_latency got=%0d exp=%0d", last_to_cyc - drop_cyc, TO + FLT + 3);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (to_cnt != t0 + 1 || done_cnt != d0 || rx_busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_after got to=%0d done=%0d busy=%0b exp to=1 done=0 busy=0",
               to_cnt - t0, done_cnt - d0, rx_busy);
    end
    push_exp(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, odd_par(8'h5A), 1'b1);
    wait_drain("after_timeout");
  endtask

  task automatic test_rx_en_abort();
    logic [7:0] d;
    int d0, t0;
    d = 8'h1C;
    d0 = done_cnt;
    t0 = to_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(d[i]);
    @(negedge clk);
    checks++;
    if (rx_busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_busy_before got=%0b exp=1", rx_busy);
    end
    rx_en = 1'b0;
    @(negedge clk);
    checks++;
    if (rx_busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_busy_after got=%0b exp=0", rx_busy);
    end
    for (int i = 3; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(odd_par(d));
    ps2_bit(1'b1);
    ps2d = 1'b1;
    repeat (TO + 50) @(negedge clk);
    rx_en = 1'b1;
    checks++;
    if (done_cnt != d0 || to_cnt != t0 || data_out !== 8'h5A) begin
      failures++;
      $display("FAIL abort_quiet got done=%0d to=%0d data=%02h exp done=0 to=0 data=5a",
               done_cnt - d0, to_cnt - t0, data_out);
    end
    // Short low pulses with ps2d low would start a frame if any edge got through
    ps2d = 1'b0;
    for (int g = 0; g < 3; g++) begin
      ps2c = 1'b0;
      repeat (3) @(negedge clk);
      ps2c = 1'b1;
      repeat (10) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (rx_busy !== 1'b0 || done_cnt != d0) begin
      failures++;
      $display("FAIL glitch_reject got busy=%0b done=%0d exp busy=0 done=0", rx_busy, done_cnt - d0);
    end
    ps2d = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int d0;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    @(negedge clk);
    checks++;
    if (rx_busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_busy_before got=%0b exp=1", rx_busy);
    end
    reset = 1'b1;
    #1;
    check_all_zero("reset_mid_async");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ps2d = 1'b1;
    repeat (5) @(negedge clk);
    check_all_zero("reset_mid_after");
    d0 = done_cnt;
    push_exp(8'hAA, 1'b0, 1'b0);
    send_frame(8'hAA, odd_par(8'hAA), 1'b1);
    wait_drain("after_reset");
    checks++;
    if (done_cnt != d0 + 1) begin
      failures++;
      $display("FAIL reset_mid_done_count got=%0d exp=%0d", done_cnt - d0, 1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_errors();
    test_timeout();
    test_rx_en_abort();
    test_reset_mid();
    repeat (10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
